// File: rtl/regbank_pkg.sv
// Shared constants, write-stage layout and pointer-wrap helper for the register-bank write arbiter.
package regbank_pkg;

  localparam int REGBANK_NREQ = 4;
  localparam int REGBANK_NREG = 4;
  localparam int REGBANK_DW   = 4;
  localparam int REGBANK_AW   = $clog2(REGBANK_NREG);
  localparam int REGBANK_IW   = $clog2(REGBANK_NREQ);

  // Write-stage entry in the default configuration.
  typedef struct packed {
    logic                  valid;
    logic [REGBANK_AW-1:0] addr;
    logic [REGBANK_DW-1:0] data;
    logic [REGBANK_IW-1:0] idx;
  } wstage_t;

  // Modulo-n increment by compare, so a non-power-of-2 n wraps correctly.
  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regbank_wr_arbiter_rr_arbiter.sv
// Combinational masked round-robin pick: the first eligible requester at or after ptr_i wins.
module rr_arbiter
  import regbank_pkg::*;
#(
  parameter  int NREQ = REGBANK_NREQ,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] mask_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_o,
  output logic [IW-1:0]   win_idx_o,
  output logic            vld_o
);

  logic [NREQ-1:0] eligible;
  logic [IW-1:0]   cand;

  always_comb begin
    eligible  = req_i & ~mask_i;
    win_o     = '0;
    win_idx_o = '0;
    vld_o     = 1'b0;
    cand      = ptr_i;
    for (int k = 0; k < NREQ; k++) begin
      if (!vld_o && eligible[cand]) begin
        vld_o       = 1'b1;
        win_o[cand] = 1'b1;
        win_idx_o   = cand;
      end
      cand = IW'(rr_wrap_inc(int'(cand), NREQ));
    end
  end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Round-robin shared write port for a small register bank: grant registered, write one cycle later.
// Optional owner tracking per register is enabled by defining REGBANK_OWNER_TRACK_EN.
module regbank_wr_arbiter
  import regbank_pkg::*;
#(
  parameter  int NREQ = REGBANK_NREQ,
  parameter  int NREG = REGBANK_NREG,
  parameter  int DW   = REGBANK_DW,
  localparam int AW   = $clog2(NREG),
  localparam int IW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  input  logic [AW-1:0]    rd_addr,
  output logic [DW-1:0]    rd_data
`ifdef REGBANK_OWNER_TRACK_EN
  ,
  output logic [IW-1:0]    rd_owner
`endif
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
`ifdef REGBANK_OWNER_TRACK_EN
    logic [IW-1:0] idx;
`endif
  } wr_stage_t;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  wr_stage_t       ws_q, ws_d;
  logic [DW-1:0]   bank_q [NREG];

  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic            win_vld;

  // The current grant masks its own held request so it is not granted twice.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i    (req),
    .mask_i   (gnt_q),
    .ptr_i    (ptr_q),
    .win_o    (win),
    .win_idx_o(win_idx),
    .vld_o    (win_vld)
  );

  always_comb begin
    gnt_d      = win;
    ptr_d      = ptr_q;
    ws_d       = '0;
    ws_d.valid = win_vld;
    ws_d.addr  = wr_addr[win_idx*AW +: AW];
    ws_d.data  = wr_data[win_idx*DW +: DW];
`ifdef REGBANK_OWNER_TRACK_EN
    ws_d.idx   = win_idx;
`endif
    if (win_vld) ptr_d = IW'(rr_wrap_inc(int'(win_idx), NREQ));
  end

  // Grant/arbitration stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q <= '0;
      ptr_q <= '0;
      ws_q  <= '0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      ws_q  <= ws_d;
    end
  end

  // Write stage: bank storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) bank_q[r] <= '0;
    end else if (ws_q.valid) begin
      bank_q[ws_q.addr] <= ws_q.data;
    end
  end

`ifdef REGBANK_OWNER_TRACK_EN
  logic [IW-1:0] owner_q [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) owner_q[r] <= '0;
    end else if (ws_q.valid) begin
      owner_q[ws_q.addr] <= ws_q.idx;
    end
  end

  assign rd_owner = owner_q[rd_addr];
`endif

  assign gnt     = gnt_q;
  assign busy    = ws_q.valid;
  assign rd_data = bank_q[rd_addr];

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed bench for regbank_wr_arbiter (default NREQ=4, NREG=4, DW=4).
module tb_regbank_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  gnt;
  logic        busy;
  logic [1:0]  rd_addr;
  logic [3:0]  rd_data;
`ifdef REGBANK_OWNER_TRACK_EN
  logic [1:0]  rd_owner;
`endif

  int n_cmp = 0;
  int n_err = 0;

  regbank_wr_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .gnt     (gnt),
    .busy    (busy),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
`ifdef REGBANK_OWNER_TRACK_EN
    ,
    .rd_owner(rd_owner)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive just after the rising edge, observe on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int          cnt [4];
  logic [3:0]  seen;
  logic [3:0]  exp_val [4] = '{4'h3, 4'h6, 4'h9, 4'hC};

  initial begin
    reset   = 1'b0;
    req     = 4'h0;
    wr_addr = 8'h00;
    wr_data = 16'h0000;
    rd_addr = 2'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Idle after reset
    for (int c = 0; c < 3; c++) begin
      mid();
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
    end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1 chk("idle_rd", 32'(rd_data), 32'h0);
    end

    // Single write: requester 0 -> addr 2, data A
    step();
    req = 4'b0001; wr_addr = 8'h02; wr_data = 16'h000A; rd_addr = 2'd2;
    mid();
    chk("w1_gnt_c0", 32'(gnt), 32'h0);
    step();
    mid();
    chk("w1_gnt_c1", 32'(gnt), 32'h1);
    chk("w1_busy_c1", 32'(busy), 32'h1);
    chk("w1_rd_nobypass", 32'(rd_data), 32'h0);
    step();
    req = 4'b0000;
    mid();
    chk("w1_gnt_c2", 32'(gnt), 32'h0);
    chk("w1_busy_c2", 32'(busy), 32'h0);
    chk("w1_rd_c2", 32'(rd_data), 32'hA);

    // All four requesting: rotation from pointer 0
    do_reset();
    wr_addr = 8'b11_10_01_00;
    wr_data = 16'hC963;
    seen = 4'h0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 9; c++) begin
      step();
      req = (c < 8) ? (4'hF & ~seen) : 4'h0;
      mid();
      if (c > 0) begin
        chk("rr_gnt", 32'(gnt), 32'(1) << ord[c-1]);
        chk("rr_busy", 32'(busy), 32'h1);
      end
      for (int i = 0; i < 4; i++) if (gnt[i]) cnt[i]++;
      seen = gnt;
    end
    step();
    mid();
    chk("rr_gnt_idle", 32'(gnt), 32'h0);
    chk("rr_busy_fall", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++) chk("rr_count", 32'(cnt[i]), 32'h2);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1 chk("rr_bank", 32'(rd_data), 32'(exp_val[a]));
    end

    // Requesters 1 and 3 both write addr 1: later write wins
    do_reset();
    wr_addr = 8'h44;
    wr_data = 16'hC050;
    rd_addr = 2'd1;
    step();
    req = 4'b1010;
    mid();
    chk("same_gnt_c0", 32'(gnt), 32'h0);
    step();
    mid();
    chk("same_gnt_c1", 32'(gnt), 32'h2);
    chk("same_rd_c1", 32'(rd_data), 32'h0);
    step();
    req = 4'b1000;
    mid();
    chk("same_gnt_c2", 32'(gnt), 32'h8);
    chk("same_rd_c2", 32'(rd_data), 32'h5);
    step();
    req = 4'b0000;
    mid();
    chk("same_gnt_c3", 32'(gnt), 32'h0);
    chk("same_rd_c3", 32'(rd_data), 32'hC);
    step();
    mid();
    chk("same_rd_c4", 32'(rd_data), 32'hC);

    // Reset during the write-stage cycle drops the write
    do_reset();
    wr_addr = 8'h30;
    wr_data = 16'h0700;
    rd_addr = 2'd3;
    step();
    req = 4'b0100;
    step();
    mid();
    chk("rst_gnt_pre", 32'(gnt), 32'h4);
    chk("rst_busy_pre", 32'(busy), 32'h1);
    reset = 1'b0;
    req   = 4'b0000;
    #1;
    chk("rst_gnt_async", 32'(gnt), 32'h0);
    chk("rst_busy_async", 32'(busy), 32'h0);
    step();
    reset = 1'b1;
    mid();
    chk("rst_bank_dropped", 32'(rd_data), 32'h0);
    step();
    req = 4'b1010;
    mid();
    step();
    mid();
    chk("rst_ptr_zero", 32'(gnt), 32'h2);
    step();
    req = 4'b0000;

`ifdef REGBANK_OWNER_TRACK_EN
    // Owner tracking
    do_reset();
    wr_addr = 8'h00;
    wr_data = 16'h9000;
    rd_addr = 2'd0;
    step();
    req = 4'b1000;
    step();
    step();
    req = 4'b0000;
    mid();
    chk("own_rd_data", 32'(rd_data), 32'h9);
    chk("own_owner", 32'(rd_owner), 32'h3);
    do_reset();
    mid();
    chk("own_after_reset", 32'(rd_owner), 32'h0);
`endif

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
